shift_unit: RTL and testbench
=============================

SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 Parameter W, default 8, data width in bits (W >= 2).
REQ-002 Parameter AW, default 4, shift-amount width in bits (2^AW - 1 >= W).
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request a new operation; sampled only in IDLE.
REQ-006 mode  input  3  operation: 000 PASS, 001 ROR, 010 ROL, 011 LSR, 100 LSL, 101 ASR, 110 RCR, 111 RCL.
REQ-007 amt  input  AW  number of single-bit steps.
REQ-008 a  input  W  operand.
REQ-009 cin  input  1  carry-in for RCR/RCL.
REQ-010 oe  input  1  bus drive enable for w.
REQ-011 w  output  W  result register when oe=1; all bits high-Z when oe=0.
REQ-012 cf  output  1  carry flag register.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 done  output  1  single-cycle completion pulse.

Function
REQ-015 The FSM SHALL have states IDLE, SHIFT and DONE, with busy = (state != IDLE) and done = (state == DONE), both decoded from registered state.
REQ-016 In IDLE with start=1, the block SHALL latch a into the data register, latch mode, load carry from cin for RCR/RCL or with 0 for all other modes, and load the step counter with the effective amount.
REQ-017 The effective amount SHALL be min(amt, W), and SHALL be forced to 0 for PASS.
REQ-018 If the effective amount is 0, the next state SHALL be DONE; otherwise it SHALL be SHIFT.
REQ-019 In SHIFT, each cycle SHALL perform exactly one 1-bit step and decrement the counter; the step that brings the counter to 0 SHALL move the FSM to DONE.
REQ-020 Step rules: ROR w={w[0],w[W-1:1]}, cf=w[0]; ROL w={w[W-2:0],w[W-1]}, cf=w[W-1].
REQ-021 Step rules: LSR w={0,w[W-1:1]}, cf=w[0]; LSL w={w[W-2:0],0}, cf=w[W-1]; ASR w={w[W-1],w[W-1:1]}, cf=w[0].
REQ-022 Step rules: RCR w={cf,w[W-1:1]}, cf=w[0]; RCL w={w[W-2:0],cf}, cf=w[W-1]; all updates simultaneous.
REQ-023 Latency: with start sampled in cycle 0 and effective amount N, done SHALL be high in cycle N+1 only, and w/cf SHALL be final from that cycle.
REQ-024 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-025 start SHALL be ignored in SHIFT and DONE: no relatch, no restart, no error.
REQ-026 A start in the IDLE cycle immediately after DONE SHALL be accepted, giving back-to-back operation.
REQ-027 The result register and cf SHALL hold their final values until the next accepted start.
REQ-028 mode, amt, a and cin changing after acceptance SHALL have no effect on the operation in progress.
REQ-029 oe SHALL affect only the w tri-state and SHALL NOT alter internal state.

Reset
REQ-030 With rst=1 at a rising edge, state SHALL go to IDLE, data register to 0, cf to 0 and counter to 0, giving busy=0 and done=0.
REQ-031 rst SHALL take priority over start and abort any operation in progress, with no done pulse for the aborted operation.

Verification (W=8, AW=4)
REQ-032 ROR, a=8'h81, amt=1, oe=1 -> done in cycle 2, w=8'hC0, cf=1.
REQ-033 ASR, a=8'h90, amt=3 -> done in cycle 4, w=8'hF2, cf=0.
REQ-034 RCL, a=8'h80, cin=0, amt=2 -> w=8'h01, cf=0 at done; busy high in cycles 1-3.
REQ-035 LSL, a=8'hFF, amt=4'd12 (clamped to 8) -> done in cycle 9, w=8'h00, cf=1; start pulses in cycles 3-5 ignored.
REQ-036 PASS, a=8'h5A, amt=7 -> done in cycle 1, w=8'h5A, cf=0; with oe=0, w=8'hZZ while done is still asserted.
REQ-037 ROL, amt=6, rst=1 in cycle 3 -> IDLE in cycle 4 with w=0, cf=0, busy=0, and no done pulse.

Source files
------------

// File: rtl/shift_unit.sv
`default_nettype none
// ============================================================================
//  Module   : shift_unit
//  Purpose  : Multi-cycle shift/rotate unit. One accepted start latches the
//             operand, mode and carry, then performs one 1-bit step per cycle
//             until the (clamped) amount is exhausted, ending in a single
//             cycle done pulse. The result register drives a tri-state bus.
//  Ports    : clk   - system clock, rising edge
//             rst   - synchronous active-high reset
//             start - request a new operation (sampled only in IDLE)
//             mode  - 000 PASS 001 ROR 010 ROL 011 LSR 100 LSL 101 ASR
//                     110 RCR 111 RCL
//             amt   - number of single-bit steps (clamped to W)
//             a     - operand
//             cin   - carry-in for RCR/RCL
//             oe    - drive enable for w
//             w     - result register, high-Z when oe=0
//             cf    - carry flag register
//             busy  - state != IDLE
//             done  - state == DONE (one-cycle pulse)
//  Revision : 1.0 - initial release
// ============================================================================
module shift_unit #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    mode,
    input  logic [AW-1:0] amt,
    input  logic [W-1:0]  a,
    input  logic          cin,
    input  logic          oe,
    output logic [W-1:0]  w,
    output logic          cf,
    output logic          busy,
    output logic          done
);

    localparam logic [2:0] C_PASS = 3'b000;
    localparam logic [2:0] C_ROR  = 3'b001;
    localparam logic [2:0] C_ROL  = 3'b010;
    localparam logic [2:0] C_LSR  = 3'b011;
    localparam logic [2:0] C_LSL  = 3'b100;
    localparam logic [2:0] C_ASR  = 3'b101;
    localparam logic [2:0] C_RCR  = 3'b110;
    localparam logic [2:0] C_RCL  = 3'b111;

    // W always fits in AW bits because 2^AW - 1 >= W.
    localparam logic [AW-1:0] C_W_AMT = AW'(W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_data;
    logic          r_cf;
    logic [2:0]    r_mode;
    logic [AW-1:0] r_cnt;

    logic [AW-1:0] w_eff_amt;
    logic [W-1:0]  w_step_data;
    logic          w_step_cf;

    // Effective amount: min(amt, W), and zero for PASS so it completes at once.
    always_comb begin
        w_eff_amt = (amt > C_W_AMT) ? C_W_AMT : amt;
        if (mode == C_PASS) begin
            w_eff_amt = '0;
        end
    end

    // One 1-bit step of the latched operation; data and carry update together.
    always_comb begin
        w_step_data = r_data;
        w_step_cf   = r_cf;
        case (r_mode)
            C_ROR: begin
                w_step_data = {r_data[0], r_data[W-1:1]};
                w_step_cf   = r_data[0];
            end
            C_ROL: begin
                w_step_data = {r_data[W-2:0], r_data[W-1]};
                w_step_cf   = r_data[W-1];
            end
            C_LSR: begin
                w_step_data = {1'b0, r_data[W-1:1]};
                w_step_cf   = r_data[0];
            end
            C_LSL: begin
                w_step_data = {r_data[W-2:0], 1'b0};
                w_step_cf   = r_data[W-1];
            end
            C_ASR: begin
                w_step_data = {r_data[W-1], r_data[W-1:1]};
                w_step_cf   = r_data[0];
            end
            C_RCR: begin
                w_step_data = {r_cf, r_data[W-1:1]};
                w_step_cf   = r_data[0];
            end
            C_RCL: begin
                w_step_data = {r_data[W-2:0], r_cf};
                w_step_cf   = r_data[W-1];
            end
            default: begin
                w_step_data = r_data;
                w_step_cf   = r_cf;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_cf    <= 1'b0;
            r_mode  <= C_PASS;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_data  <= a;
                        r_mode  <= mode;
                        r_cf    <= ((mode == C_RCR) || (mode == C_RCL)) ? cin : 1'b0;
                        r_cnt   <= w_eff_amt;
                        r_state <= (w_eff_amt == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    r_data <= w_step_data;
                    r_cf   <= w_step_cf;
                    r_cnt  <= r_cnt - 1'b1;
                    // Counter holds the steps still to do, so 1 means this is the last.
                    if (r_cnt == AW'(1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w    = oe ? r_data : {W{1'bz}};
    assign cf   = r_cf;
    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_unit
//  Purpose  : Directed self-checking bench for shift_unit (W=8, AW=4).
//             Inputs change 1 time unit after a rising edge; outputs are
//             checked at the same point, i.e. in the cycle just entered.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_unit;

    localparam int W  = 8;
    localparam int AW = 4;

    localparam logic [2:0] C_PASS = 3'b000;
    localparam logic [2:0] C_ROR  = 3'b001;
    localparam logic [2:0] C_ROL  = 3'b010;
    localparam logic [2:0] C_LSR  = 3'b011;
    localparam logic [2:0] C_LSL  = 3'b100;
    localparam logic [2:0] C_ASR  = 3'b101;
    localparam logic [2:0] C_RCR  = 3'b110;
    localparam logic [2:0] C_RCL  = 3'b111;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    mode;
    logic [AW-1:0] amt;
    logic [W-1:0]  a;
    logic          cin;
    logic          oe;
    wire  [W-1:0]  w;
    logic          cf;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen;

    shift_unit #(.W(W), .AW(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .amt   (amt),
        .a     (a),
        .cin   (cin),
        .oe    (oe),
        .w     (w),
        .cf    (cf),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present an operation in the current cycle (cycle 0); returns in cycle 1.
    task automatic go(input logic [2:0] m, input logic [7:0] av,
                      input logic [3:0] n, input logic c);
        mode  = m;
        a     = av;
        amt   = n;
        cin   = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = C_PASS; amt = '0; a = '0; cin = 1'b0; oe = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_w",    32'(w),    32'h00);
        check("rst_cf",   32'(cf),   32'd0);

        // ROR 0x81 by 1: done in cycle 2, w=C0 cf=1
        go(C_ROR, 8'h81, 4'd1, 1'b0);
        check("ror_c1_busy", 32'(busy), 32'd1);
        check("ror_c1_done", 32'(done), 32'd0);
        tick();
        check("ror_done", 32'(done), 32'd1);
        check("ror_w",    32'(w),    32'hC0);
        check("ror_cf",   32'(cf),   32'd1);
        tick();
        check("ror_idle_done", 32'(done), 32'd0);
        check("ror_hold_w",    32'(w),    32'hC0);

        // Back-to-back: start in the IDLE cycle right after DONE. LSR 0x03 by 1 -> 01, cf=1
        go(C_LSR, 8'h03, 4'd1, 1'b0);
        check("b2b_busy", 32'(busy), 32'd1);
        tick();
        check("lsr_done", 32'(done), 32'd1);
        check("lsr_w",    32'(w),    32'h01);
        check("lsr_cf",   32'(cf),   32'd1);
        tick();

        // ASR 0x90 by 3 with inputs scrambled after acceptance: done in cycle 4, F2 cf=0
        go(C_ASR, 8'h90, 4'd3, 1'b1);
        mode = C_PASS; a = 8'h00; amt = 4'd0; cin = 1'b1;
        tick();
        tick();
        check("asr_c3_done", 32'(done), 32'd0);
        tick();
        check("asr_done", 32'(done), 32'd1);
        check("asr_w",    32'(w),    32'hF2);
        check("asr_cf",   32'(cf),   32'd0);
        tick();

        // RCL 0x80 cin=0 by 2: busy cycles 1-3, w=01 cf=0
        go(C_RCL, 8'h80, 4'd2, 1'b0);
        check("rcl_c1_busy", 32'(busy), 32'd1);
        tick();
        check("rcl_c2_busy", 32'(busy), 32'd1);
        tick();
        check("rcl_c3_busy", 32'(busy), 32'd1);
        check("rcl_done",    32'(done), 32'd1);
        check("rcl_w",       32'(w),    32'h01);
        check("rcl_cf",      32'(cf),   32'd0);
        tick();
        check("rcl_c4_busy", 32'(busy), 32'd0);

        // LSL 0xFF with amt 12 clamped to 8; start pulses in cycles 3-5 ignored
        go(C_LSL, 8'hFF, 4'd12, 1'b0);
        tick();
        tick();
        start = 1'b1; mode = C_PASS; a = 8'h5A; amt = 4'd0;
        tick();
        tick();
        tick();
        start = 1'b0;
        tick();
        tick();
        check("lsl_c8_done", 32'(done), 32'd0);
        check("lsl_c8_busy", 32'(busy), 32'd1);
        tick();
        check("lsl_done", 32'(done), 32'd1);
        check("lsl_w",    32'(w),    32'h00);
        check("lsl_cf",   32'(cf),   32'd1);
        tick();
        check("lsl_c10_busy", 32'(busy), 32'd0);

        // PASS 0x5A, amt ignored: done in cycle 1, w=5A cf=0; high-Z while oe=0
        oe = 1'b0;
        go(C_PASS, 8'h5A, 4'd7, 1'b1);
        check("pass_done", 32'(done), 32'd1);
        check("pass_cf",   32'(cf),   32'd0);
        n_checks++;
        assert (w === 8'bzzzzzzzz) else begin
            n_fail++;
            $error("FAIL pass_hiz: observed %h expected zz", w);
        end
        oe = 1'b1;
        #1;
        check("pass_w",      32'(w),    32'h5A);
        check("pass_done_2", 32'(done), 32'd1);
        tick();

        // RCR 0x00 cin=1 by 1 -> 80, cf=0
        go(C_RCR, 8'h00, 4'd1, 1'b1);
        tick();
        check("rcr_done", 32'(done), 32'd1);
        check("rcr_w",    32'(w),    32'h80);
        check("rcr_cf",   32'(cf),   32'd0);
        tick();

        // ROL 0x81 by 1 -> 03, cf=1
        go(C_ROL, 8'h81, 4'd1, 1'b0);
        tick();
        check("rol_w",  32'(w),  32'h03);
        check("rol_cf", 32'(cf), 32'd1);
        tick();

        // ROL by 6 aborted by reset in cycle 3: IDLE in cycle 4, cleared, no done
        go(C_ROL, 8'h81, 4'd6, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_w",    32'(w),    32'h00);
        check("abort_cf",   32'(cf),   32'd0);
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) done_seen++;
            tick();
        end
        check("abort_no_done", 32'(done_seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
